// File: rtl/cache_block_mem_adapter_pkg.sv
// Shared widths, state encoding and block request/response types for the
// cache-to-main-memory block adapter.
package cache_block_mem_adapter_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int WORD_WIDTH = 32;
    localparam int BLOCK_SIZE = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int OFFSET_WIDTH  = clog2(BLOCK_SIZE);
    // A one-word block still needs a legal (1-bit) counter that simply stays at 0.
    localparam int BLK_CNT_WIDTH = (BLOCK_SIZE > 1) ? OFFSET_WIDTH : 1;

    typedef enum logic [1:0] {
        AD_IDLE,
        AD_XFER,
        AD_DONE
    } adapter_state_t;

    typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_data_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  cs;
        logic                  rw;
        block_data_t           data;
    } memory_request_t;

    typedef struct packed {
        logic        ack;
        block_data_t data;
    } memory_response_t;

endpackage

// File: rtl/cache_block_mem_adapter_if.sv
// Bundle of the block-side request/response and the word-wide memory bus
// seen by the block adapter.
interface cache_block_mem_adapter_if;
    import cache_block_mem_adapter_pkg::*;

    memory_request_t         mem_req;
    memory_response_t        mem_rsp;
    logic                    busy;
    logic                    word_cs;
    logic                    word_we;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [WORD_WIDTH-1:0]   word_wdata;
    logic [WORD_WIDTH-1:0]   word_rdata;
    logic                    word_ready;

    modport slave (
        input  mem_req,
        input  word_rdata,
        input  word_ready,
        output mem_rsp,
        output busy,
        output word_cs,
        output word_we,
        output word_addr,
        output word_wdata
    );

    modport master (
        output mem_req,
        output word_rdata,
        output word_ready,
        input  mem_rsp,
        input  busy,
        input  word_cs,
        input  word_we,
        input  word_addr,
        input  word_wdata
    );

endinterface

// File: rtl/cache_block_mem_adapter.sv
// Serialises one block read/write from the cache into BLOCK_SIZE single-word
// accesses and returns a one-cycle ack carrying the whole block.
module cache_block_mem_adapter
    import cache_block_mem_adapter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    cache_block_mem_adapter_if.slave bus_io
);

    localparam logic [ADDR_WIDTH-1:0]    BLOCK_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [BLK_CNT_WIDTH-1:0] LAST_COUNT = BLK_CNT_WIDTH'(BLOCK_SIZE - 1);

    adapter_state_t             state_q;
    logic [BLK_CNT_WIDTH-1:0]   count_q;
    logic [BLK_CNT_WIDTH-1:0]   count_d;
    logic                       rw_q;
    block_data_t                wdata_q;
    block_data_t                rdata_q;
    block_data_t                rdata_d;
    block_data_t                rsp_data_q;
    logic                       ack_q;
    logic                       word_cs_q;
    logic                       word_we_q;
    logic [ADDR_WIDTH-1:0]      word_addr_q;
    logic [WORD_WIDTH-1:0]      word_wdata_q;

    assign count_d = count_q + BLK_CNT_WIDTH'(1);

    // Read buffer including the word arriving this cycle, so the final word
    // lands directly in the response without an extra cycle.
    always_comb begin
        rdata_d          = rdata_q;
        rdata_d[count_q] = bus_io.word_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= AD_IDLE;
            count_q      <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rsp_data_q   <= '0;
            ack_q        <= 1'b0;
            word_cs_q    <= 1'b0;
            word_we_q    <= 1'b0;
            word_addr_q  <= '0;
            word_wdata_q <= '0;
        end else begin
            case (state_q)
                AD_IDLE: begin
                    if (bus_io.mem_req.cs) begin
                        state_q      <= AD_XFER;
                        count_q      <= '0;
                        rw_q         <= bus_io.mem_req.rw;
                        wdata_q      <= bus_io.mem_req.data;
                        word_cs_q    <= 1'b1;
                        word_we_q    <= bus_io.mem_req.rw;
                        word_addr_q  <= bus_io.mem_req.addr & BLOCK_MASK;
                        word_wdata_q <= bus_io.mem_req.data[0];
                    end
                end
                AD_XFER: begin
                    if (bus_io.word_ready) begin
                        if (!rw_q) begin
                            rdata_q <= rdata_d;
                        end
                        if (count_q == LAST_COUNT) begin
                            state_q    <= AD_DONE;
                            word_cs_q  <= 1'b0;
                            ack_q      <= 1'b1;
                            rsp_data_q <= rw_q ? wdata_q : rdata_d;
                        end else begin
                            // Base is block-aligned, so this increment never carries out of the offset bits.
                            count_q      <= count_d;
                            word_addr_q  <= word_addr_q + ADDR_WIDTH'(1);
                            word_wdata_q <= wdata_q[count_d];
                        end
                    end
                end
                AD_DONE: begin
                    state_q <= AD_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= AD_IDLE;
                end
            endcase
        end
    end

    assign bus_io.busy         = (state_q != AD_IDLE);
    assign bus_io.word_cs      = word_cs_q;
    assign bus_io.word_we      = word_we_q;
    assign bus_io.word_addr    = word_addr_q;
    assign bus_io.word_wdata   = word_wdata_q;
    assign bus_io.mem_rsp.ack  = ack_q;
    assign bus_io.mem_rsp.data = rsp_data_q;

endmodule

// File: doc/cache_block_mem_adapter.md
Name: cache_block_mem_adapter

Overview:
Sits directly downstream of the cache controller's memory port. Consumes one block request (memory_request_t: BLOCK_SIZE words, read or write) and serialises it into BLOCK_SIZE single-word accesses on the word-wide main-memory bus. Returns a one-cycle ack with the assembled block (memory_response_t). Serves both the allocate (block read) and write_back (block write) states of the cache controller.

Parameters:
BLOCK_SIZE, cache_parameters::BLOCK_SIZE (2), words per block; power of two, >=1.
ADDR_WIDTH, memory_mapping::ADDR_WIDTH, word-address width.
WORD_WIDTH, memory_mapping::WORD_WIDTH, data word width.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
mem_req  in  memory_request_t  block request from cache (addr, cs, rw: 0 read / 1 write, data[BLOCK_SIZE]).
mem_rsp  out  memory_response_t  ack pulse plus data[BLOCK_SIZE].
busy  out  1  high while a request is in flight (XFER or DONE).
word_cs  out  1  word access strobe to main memory.
word_we  out  1  1 = write word, 0 = read word.
word_addr  out  ADDR_WIDTH  word address.
word_wdata  out  WORD_WIDTH  write data.
word_rdata  in  WORD_WIDTH  read data, valid when word_ready=1.
word_ready  in  1  memory completes current word access this cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0; mem_rsp.ack=0, mem_rsp.data[*]=0, busy=0, word_cs=0, word_we=0, word_addr=0, word_wdata=0. Deasserting mid-transfer aborts it; no ack is issued for the aborted request.
- States (adapter_state_t): AD_IDLE, AD_XFER, AD_DONE.
- AD_IDLE: if mem_req.cs=1 at a rising edge, latch base = {mem_req.addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'b0}, rw, and write data[BLOCK_SIZE]; count<=0; go to AD_XFER. Low offset bits of mem_req.addr are ignored (block-aligned).
- AD_XFER: word_cs=1, word_we=latched rw, word_addr=base+count, word_wdata=latched data[count]. All four are decoded from registered state/count/latches, with no combinational path from mem_req. Hold everything stable until word_ready=1. On word_ready: if read, rdata_buf[count]<=word_rdata. If count==BLOCK_SIZE-1, go to AD_DONE, otherwise count<=count+1.
- AD_DONE: word_cs=0; mem_rsp.ack=1 for exactly this one cycle; mem_rsp.data = rdata_buf for reads, latched write data for writes. Unconditionally return to AD_IDLE. mem_req.cs is ignored in this cycle, because the cache still shows its old state.
- mem_rsp.data holds its value after ack until the next request reaches AD_DONE.
- busy = (state != AD_IDLE).
- Latency with zero-wait memory (word_ready tied 1): accept edge T; word k issued in cycle T+1+k; ack in cycle T+1+BLOCK_SIZE. Each wait cycle (word_ready=0) adds one cycle.
- Back-to-back: a request with cs=1 in the cycle after ack (e.g. write_back followed by allocate) is accepted in that AD_IDLE cycle. There is no dead cycle beyond AD_DONE.
- Address arithmetic: base+count is an ADDR_WIDTH-bit add that cannot carry past the block because base is aligned. word_addr wraps modulo 2^ADDR_WIDTH only at the top block.
- word_ready while word_cs=0 is ignored.
- BLOCK_SIZE=1: count is 1 bit held at 0; a single word is issued per request.

Decomposition:
- cache_parameters gains the typedef enum adapter_state_t {AD_IDLE, AD_XFER, AD_DONE}.
- It also gains the constant BLK_CNT_WIDTH = (BLOCK_SIZE>1) ? OFFSET_WIDTH : 1.
- memory_request_t and memory_response_t are reused unchanged from cache_parameters.
- ADDR_WIDTH, WORD_WIDTH and clog2 come from memory_mapping.
- No sub-module; a single FSM plus a counter, comfortably within 200 lines.

Test Plan:
- Block read, zero-wait (BLOCK_SIZE=2, addr=0x13, memory[0x12]=0xAAAA0001, memory[0x13]=0xAAAA0002) -> word reads at 0x12 then 0x13 in consecutive cycles; ack in cycle T+3 with data={0xAAAA0001,0xAAAA0002}; ack high exactly 1 cycle.
- Block write, 2 wait states per word (addr=0x40, data={0x11,0x22}) -> word_we=1; addr/wdata stable across waits; memory[0x40]=0x11 and memory[0x41]=0x22; ack at T+7.
- Back-to-back: write 0x40 then cs held with rw=0, addr=0x80 in the cycle after ack -> second request accepted with no idle gap; reads 0x80 and 0x81; two distinct acks.
- Reset mid-transfer (rst_n low during word 1 of a read) -> word_cs falls asynchronously; no ack; all outputs 0; a fresh request afterwards completes normally.
- cs held high through AD_DONE with unchanged request -> exactly one transfer per accept; no spurious re-issue in the ack cycle. Top address 0x...FE block -> word_addr 0x...FE, 0x...FF, with no overflow into the tag bits.
